// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared types and constants for the RV32 instruction fetch
//                front end (FSM states, buffered entry layout, PC helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_WAIT  = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of fetch entries. Head is presented
//                combinationally from storage; flush beats push.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           wdata_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o,
  output logic                   empty_o,
  output logic                   full_o
);

  // DEPTH must be a power of two >= 2 so the pointers wrap naturally.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push on a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  // Next pointer / occupancy; flush empties the buffer outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32 fetch front end. Owns the PC, issues one word read at a
//                time to instruction memory, buffers returned words and hands
//                {raw, pc} to the decoder. Redirects flush the buffer and any
//                in-flight read is discarded on return.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_raw_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;   // address of the outstanding request

  logic          req_valid;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Only ask for a word when a buffer slot is guaranteed free on its return.
  assign req_valid = !rst && (state_q == FS_REQ) && (fifo_count < CW'(FIFO_DEPTH));
  assign accept    = req_valid && imem_req_ready_i;
  assign pop       = !fifo_empty && instr_ready_i;

  // Next-state, PC update and push decision; redirect overrides normal flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    push_entry = '{pc: req_pc_q, raw: imem_rsp_data_i};
    if (redirect_valid_i) begin
      pc_d = word_align(redirect_pc_i);
      case (state_q)
        FS_REQ:   state_d = accept ? FS_FLUSH : FS_REQ;
        FS_WAIT,
        FS_FLUSH: state_d = imem_rsp_valid_i ? FS_REQ : FS_FLUSH;
        default:  state_d = FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_REQ: begin
          if (accept) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
            state_d  = FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_rsp_valid_i) begin
            push    = 1'b1;
            state_d = FS_REQ;
          end
        end
        FS_FLUSH: begin
          if (imem_rsp_valid_i) state_d = FS_REQ;
        end
        default: state_d = FS_REQ;
      endcase
    end
  end

  // FSM state, PC and outstanding-request address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_REQ;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid_i),
    .wdata_i (push_entry),
    .count_o (fifo_count),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign instr_valid_o    = !fifo_empty;
  assign instr_raw_o      = head.raw;
  assign instr_pc_o       = head.pc;

  // A response with nothing outstanding means the memory broke protocol.
  a_rsp_without_req : assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid_i && state_q == FS_REQ));

  // Request gating must make a push into a full buffer impossible.
  a_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule
`default_nettype wire
